// File: rtl/sum_accumulator.sv
// Batch-summing stage: accepts adder results over valid/ready, accumulates `len` of them, presents total + sticky overflow.
// Optional build macro SUM_ACC_SATURATE_EN: clamp the total to all-ones on carry-out instead of wrapping.
module sum_accumulator #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_total,
    output logic               out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   acc_r, acc_nxt_s;
    logic               ovf_r, ovf_nxt_s;
    logic [COUNT_W-1:0] remaining_r, remaining_nxt_s;
    logic [WIDTH:0]     sum_wide_s;
    logic               beat_s;

    // Unsigned add one bit wider than the operands so the carry-out is bit WIDTH.
    function automatic logic [WIDTH:0] add_wide(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign sum_wide_s = add_wide(acc_r, in_sum);
    assign beat_s     = in_valid && (state_r == ACCUM);

    // Handshake flags decode from the state register only.
    assign busy      = (state_r != IDLE);
    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == DONE);
    assign out_total = acc_r;
    assign out_ovf   = ovf_r;

    // Next-state and datapath update.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        ovf_nxt_s       = ovf_r;
        remaining_nxt_s = remaining_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_nxt_s       = '0;
                    ovf_nxt_s       = 1'b0;
                    remaining_nxt_s = len;
                    if (len != '0) begin
                        state_nxt_s = ACCUM;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s) begin
                    if (sum_wide_s[WIDTH]) begin
                        ovf_nxt_s = 1'b1;
`ifdef SUM_ACC_SATURATE_EN
                        acc_nxt_s = {WIDTH{1'b1}};
`else
                        acc_nxt_s = sum_wide_s[WIDTH-1:0];
`endif
                    end else begin
                        acc_nxt_s = sum_wide_s[WIDTH-1:0];
                    end
                    remaining_nxt_s = remaining_r - CNT_ONE;
                    if (remaining_r == CNT_ONE) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            remaining_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            ovf_r       <= ovf_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 32-bit ripple-carry adder. It accepts a stream of adder results over a valid/ready handshake and accumulates a software-specified number of them into a running unsigned total. It then presents the final total and an overflow flag on an output handshake. It converts the single-cycle combinational adder into a batch-summing datapath stage.

## Interface
- WIDTH, 32: data width; matches adder `answer` width.
- COUNT_W, 8: width of batch length; max batch = 2^COUNT_W − 1 samples.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a batch; honoured only in IDLE.
- len  input  COUNT_W  number of samples in the batch; sampled when `start` is accepted.
- busy  output  1  high in ACCUM and DONE.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  WIDTH  sample value (adder result).
- out_valid  output  1  final total available.
- out_ready  input  1  downstream accepts total.
- out_total  output  WIDTH  accumulated total.
- out_ovf  output  1  at least one unsigned carry-out occurred during this batch.

## Operation
- States:
  - IDLE: no batch in progress.
  - ACCUM: accepting samples.
  - DONE: final total presented.
- IDLE: `in_ready` = 0, `out_valid` = 0, `busy` = 0.
  - `start` = 1 with `len` ≠ 0: clear accumulator and overflow, load `remaining` ← `len`, go to ACCUM.
  - `start` = 1 with `len` = 0: clear accumulator and overflow, go directly to DONE; result is total 0, ovf 0.
- ACCUM: `in_ready` = 1.
  - A beat is accepted when `in_valid` && `in_ready`.
  - On each accepted beat: acc ← acc + `in_sum`, computed at WIDTH+1 bits. If bit WIDTH is 1, set sticky ovf.
  - On each accepted beat: `remaining` decrements.
  - The beat taken when `remaining` = 1 is the last one; go to DONE.
  - No accepted beat: hold all state.
- DONE: `in_ready` = 0, `out_valid` = 1.
  - `out_total` and `out_ovf` stay stable until handshake.
  - `out_valid` && `out_ready`: go to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Arithmetic is unsigned. The default overflow behaviour wraps modulo 2^WIDTH (see Configuration).
- `out_total` always reflects the accumulator register, so its value is visible mid-batch. It is only defined as the result while `out_valid` = 1.

## Timing
- Reset values:
  - outputs: `busy` 0, `in_ready` 0, `out_valid` 0, `out_total` 0, `out_ovf` 0.
  - internal: state IDLE, `remaining` 0.
- `in_ready`, `out_valid` and `busy` decode from the registered state only. There is no combinational path from any input.
- `start` accepted at edge N: `in_ready` = 1 in cycle N+1.
- Last beat accepted at edge M: `out_valid` = 1 in cycle M+1, with the final total and ovf.
- Throughput is one sample per cycle while `in_valid` is held high. A batch of L samples with no stalls reaches `out_valid` L+1 cycles after `start`.
- Output handshake at edge K: IDLE in cycle K+1. The earliest next `start` is accepted at edge K+1.
- `start` in the same cycle as the output handshake is ignored, because the block is not yet in IDLE.
- `rst` mid-batch aborts the batch on the next edge. No output is produced, and all values return to their reset values.

## Configuration
- `SUM_ACC_SATURATE_EN`:
  - Defined: on a carry-out the accumulator is forced to all-ones (2^WIDTH − 1) and ovf is set. Later beats keep it saturated.
  - Undefined: the accumulator wraps modulo 2^WIDTH, ovf is still set, and later beats continue from the wrapped value.
- Handshake timing is identical in both builds.

## Test plan
- Reset, then `start`, `len`=3, samples 10, 20, 30 with no stalls → `out_valid` 4 cycles after `start`, `out_total`=60, `out_ovf`=0. IDLE the cycle after handshake.
- `len`=4, `in_valid` toggled 1,0,1,0,… → exactly 4 beats accepted, `out_total` correct, no beat accepted while in DONE.
- `len`=2, samples 0xFFFF_FFF0 and 0x20 → `out_ovf`=1. Without macro `out_total`=0x0000_0010; with `SUM_ACC_SATURATE_EN` `out_total`=0xFFFF_FFFF.
- `len`=0 → DONE one cycle after `start`, `out_total`=0, `out_ovf`=0. Hold `out_ready`=0 for 5 cycles → outputs stable, then handshake returns to IDLE.
- Pulse `start` during ACCUM and again in the handshake cycle → both ignored. `rst` after 2 of 5 beats → all outputs 0 next cycle, and a new batch starts cleanly.
